// File: rtl/dm_main_mem_ctrl_if.sv
// Memory request/response bundle between the direct-mapped cache controller and its
// line memory.
interface dm_main_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_data_ready;
  logic [LINE_W-1:0] mem_data_data;

  modport master (
    output mem_req_valid,
    output mem_req_rw,
    output mem_req_addr,
    output mem_req_data,
    input  mem_data_ready,
    input  mem_data_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_rw,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_data_ready,
    output mem_data_data
  );

endinterface

// File: rtl/dm_main_mem_ctrl.sv
// Fixed-latency 128-bit line memory responder for the direct-mapped cache controller.
// Optional read/write request counters are enabled by defining MEMC_PERF_CNT_EN.
module dm_main_mem_ctrl #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 128
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MEMC_PERF_CNT_EN
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
`endif
  dm_main_mem_ctrl_if.slave  mem
);

  localparam int unsigned Lines = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dm_main_mem_ctrl: LATENCY must be in 1..15");
    end
    if (LINE_W != 128) begin : g_bad_line_w
      $error("dm_main_mem_ctrl: LINE_W must be 128");
    end
    if (ADDR_W < DEPTH_LOG2 + 4) begin : g_bad_addr_w
      $error("dm_main_mem_ctrl: ADDR_W too narrow for DEPTH_LOG2");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [LINE_W-1:0]     resp_q;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] idx;

  logic [LINE_W-1:0]     line_mem [Lines];

  // Upper address bits are dropped so the array aliases across the address space.
  assign idx = mem.mem_req_addr[DEPTH_LOG2+3:4];

  generate
    if (ADDR_W > DEPTH_LOG2 + 4) begin : g_unused_hi
      logic unused_addr;
      assign unused_addr = ^{mem.mem_req_addr[ADDR_W-1:DEPTH_LOG2+4], mem.mem_req_addr[3:0]};
    end else begin : g_unused_lo
      logic unused_addr;
      assign unused_addr = ^mem.mem_req_addr[3:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (mem.mem_req_valid) begin
          accept  = 1'b1;
          cnt_d   = LatM1;
          state_d = (LATENCY == 1) ? StDone : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        // Requests arriving here are dropped; the requester holds until ready.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response register only moves at acceptance; writes return an all-zero line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
    end else if (accept) begin
      resp_q <= mem.mem_req_rw ? '0 : line_mem[idx];
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && mem.mem_req_rw) begin
      line_mem[idx] <= mem.mem_req_data;
    end
  end

  assign mem.mem_data_ready = (state_q == StDone);
  assign mem.mem_data_data  = resp_q;

`ifdef MEMC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (accept) begin
      if (mem.mem_req_rw) begin
        if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_main_mem_ctrl.sv
// Directed bench for dm_main_mem_ctrl: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_dm_main_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_11223344_55667788;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
  localparam logic [127:0] D4 = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] D5 = 128'hFEDCBA98_76543210_FEDCBA98_76543210;

  always #5 clk = ~clk;

  dm_main_mem_ctrl_if #(.ADDR_W(32), .LINE_W(128)) bus_a ();
  dm_main_mem_ctrl_if #(.ADDR_W(32), .LINE_W(128)) bus_b ();

`ifdef MEMC_PERF_CNT_EN
  logic [31:0] rd_a, wr_a, rd_b, wr_b;
`endif

  dm_main_mem_ctrl #(.LATENCY(4), .DEPTH_LOG2(10), .ADDR_W(32), .LINE_W(128)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
`ifdef MEMC_PERF_CNT_EN
    .rd_count (rd_a),
    .wr_count (wr_a),
`endif
    .mem      (bus_a)
  );

  dm_main_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(10), .ADDR_W(32), .LINE_W(128)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
`ifdef MEMC_PERF_CNT_EN
    .rd_count (rd_b),
    .wr_count (wr_b),
`endif
    .mem      (bus_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    bus_a.mem_req_valid = 1'b1;
    bus_a.mem_req_rw    = rw;
    bus_a.mem_req_addr  = addr;
    bus_a.mem_req_data  = data;
    edges(1);
    bus_a.mem_req_valid = 1'b0;
  endtask

  task automatic issue_b(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    bus_b.mem_req_valid = 1'b1;
    bus_b.mem_req_rw    = rw;
    bus_b.mem_req_addr  = addr;
    bus_b.mem_req_data  = data;
    edges(1);
    bus_b.mem_req_valid = 1'b0;
  endtask

  // Full LATENCY=4 transaction: ready only in the cycle after edge E+3.
  task automatic run_a(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [127:0] data, input logic [127:0] exp);
    issue_a(rw, addr, data);
    chk({tag, "_rdy_e0"}, 128'(bus_a.mem_data_ready), 128'd0);
    edges(2);
    chk({tag, "_rdy_e2"}, 128'(bus_a.mem_data_ready), 128'd0);
    edges(1);
    chk({tag, "_rdy_e3"}, 128'(bus_a.mem_data_ready), 128'd1);
    chk({tag, "_data"}, bus_a.mem_data_data, exp);
    edges(1);
    chk({tag, "_rdy_e4"}, 128'(bus_a.mem_data_ready), 128'd0);
  endtask

  initial begin
    bus_a.mem_req_valid = 1'b0;
    bus_a.mem_req_rw    = 1'b0;
    bus_a.mem_req_addr  = '0;
    bus_a.mem_req_data  = '0;
    bus_b.mem_req_valid = 1'b0;
    bus_b.mem_req_rw    = 1'b0;
    bus_b.mem_req_addr  = '0;
    bus_b.mem_req_data  = '0;

    #1;
    chk("reset_rdy", 128'(bus_a.mem_data_ready), 128'd0);
    chk("reset_data", bus_a.mem_data_data, 128'd0);
    edges(2);
    rst = 1'b0;
    edges(1);

    run_a("wr40", 1'b1, 32'h0000_0040, D1, 128'd0);
    run_a("rd40", 1'b0, 32'h0000_0040, 128'd0, D1);
    run_a("wr80", 1'b1, 32'h0000_0080, D2, 128'd0);

    // Back-to-back: read issued during the DONE cycle of a write.
    issue_a(1'b1, 32'h0000_0040, D3);
    edges(3);
    chk("b2b_wr_rdy", 128'(bus_a.mem_data_ready), 128'd1);
    chk("b2b_wr_data", bus_a.mem_data_data, 128'd0);
    issue_a(1'b0, 32'h0000_0080, 128'd0);
    chk("b2b_acc_rdy", 128'(bus_a.mem_data_ready), 128'd0);
    chk("b2b_acc_data", bus_a.mem_data_data, D2);
    edges(2);
    chk("b2b_rdy_e2", 128'(bus_a.mem_data_ready), 128'd0);
    edges(1);
    chk("b2b_rdy_e3", 128'(bus_a.mem_data_ready), 128'd1);
    chk("b2b_data", bus_a.mem_data_data, D2);
    edges(1);
    chk("b2b_rdy_e4", 128'(bus_a.mem_data_ready), 128'd0);

    // Valid pulse during WAIT is ignored.
    issue_a(1'b0, 32'h0000_0040, 128'd0);
    issue_a(1'b0, 32'h0000_0080, 128'd0);
    chk("wait_rdy_e1", 128'(bus_a.mem_data_ready), 128'd0);
    chk("wait_data_e1", bus_a.mem_data_data, D3);
    edges(1);
    chk("wait_rdy_e2", 128'(bus_a.mem_data_ready), 128'd0);
    edges(1);
    chk("wait_rdy_e3", 128'(bus_a.mem_data_ready), 128'd1);
    chk("wait_data", bus_a.mem_data_data, D3);
    edges(1);
    chk("wait_rdy_e4", 128'(bus_a.mem_data_ready), 128'd0);
    edges(4);
    chk("wait_no_2nd", 128'(bus_a.mem_data_ready), 128'd0);
    chk("wait_hold", bus_a.mem_data_data, D3);

    // Reset two cycles into a read.
    issue_a(1'b0, 32'h0000_0080, 128'd0);
    edges(1);
    chk("rst_pre_data", bus_a.mem_data_data, D2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_data", bus_a.mem_data_data, 128'd0);
    chk("rst_async_rdy", 128'(bus_a.mem_data_ready), 128'd0);
    edges(2);
    rst = 1'b0;
    edges(4);
    chk("rst_no_rdy", 128'(bus_a.mem_data_ready), 128'd0);

    // Alias: 0x4010 and 0x0010 map to the same line.
    run_a("alias_wr", 1'b1, 32'h0000_4010, D4, 128'd0);
    run_a("alias_rd", 1'b0, 32'h0000_0010, 128'd0, D4);
`ifdef MEMC_PERF_CNT_EN
    chk("perf_wr", 128'(wr_a), 128'd1);
    chk("perf_rd", 128'(rd_a), 128'd1);
`endif
    run_a("post_rst_rd", 1'b0, 32'h0000_0040, 128'd0, D3);

    // LATENCY=1 instance.
    issue_b(1'b1, 32'h0000_0020, D5);
    chk("l1_wr_rdy", 128'(bus_b.mem_data_ready), 128'd1);
    chk("l1_wr_data", bus_b.mem_data_data, 128'd0);
    edges(1);
    chk("l1_wr_idle", 128'(bus_b.mem_data_ready), 128'd0);
    issue_b(1'b0, 32'h0000_0020, 128'd0);
    chk("l1_rd_rdy", 128'(bus_b.mem_data_ready), 128'd1);
    chk("l1_rd_data", bus_b.mem_data_data, D5);
    edges(1);
    chk("l1_rd_idle", 128'(bus_b.mem_data_ready), 128'd0);
    chk("l1_rd_hold", bus_b.mem_data_data, D5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
